// File: rtl/vec_scale.sv
// Two-stage elastic scaler: multiplies every vector element by a signed Q-format
// scale, rounds half toward +inf and saturates, feeding the vector adder.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 16
`endif

module vec_scale #(
  parameter int VEC_LEN    = `MAX_EMBEDDING_DIM,
  parameter int DATA_WIDTH = `INTEGER_WIDTH,
  parameter int FRAC_BITS  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vld_in,
  output logic                          rdy_out,
  input  logic [VEC_LEN*DATA_WIDTH-1:0] vec_in,
  input  logic signed [DATA_WIDTH-1:0]  scale_in,
  output logic                          vld_out,
  input  logic                          rdy_in,
  output logic [VEC_LEN*DATA_WIDTH-1:0] vec_out
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = PW + 1;
  localparam logic signed [RW-1:0] HALF  = RW'(64'sd1 <<< (FRAC_BITS - 1));
  localparam logic signed [RW-1:0] MAX_R = RW'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MIN_R = -MAX_R - RW'(1);

  // One guard bit above the product keeps the rounding add from wrapping.
  function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [RW-1:0] r;
    r = (RW'(p) + HALF) >>> FRAC_BITS;
    if (r > MAX_R)      return MAX_R[DATA_WIDTH-1:0];
    else if (r < MIN_R) return MIN_R[DATA_WIDTH-1:0];
    else                return r[DATA_WIDTH-1:0];
  endfunction

  logic [VEC_LEN*DATA_WIDTH-1:0] vec_p1;
  logic signed [DATA_WIDTH-1:0]  scale_p1;
  logic                          vld_p1;
  logic [VEC_LEN*DATA_WIDTH-1:0] vec_p2;
  logic                          vld_p2;
  logic                          en1;
  logic                          en2;
  logic [VEC_LEN*DATA_WIDTH-1:0] scaled;

  assign en2     = !vld_p2 || rdy_in;
  assign en1     = !vld_p1 || en2;
  assign rdy_out = en1;
  assign vld_out = vld_p2;
  assign vec_out = vec_p2;

  always_comb begin
    logic signed [PW-1:0] prod;
    scaled = '0;
    prod   = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      prod = PW'($signed(vec_p1[i*DATA_WIDTH +: DATA_WIDTH])) * PW'(scale_p1);
      scaled[i*DATA_WIDTH +: DATA_WIDTH] = round_sat(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_p1   <= '0;
      scale_p1 <= '0;
      vld_p1   <= 1'b0;
      vec_p2   <= '0;
      vld_p2   <= 1'b0;
    end else begin
      // stage 1: capture operands
      if (en1) begin
        vec_p1   <= vec_in;
        scale_p1 <= scale_in;
        vld_p1   <= vld_in;
      end
      // stage 2: capture rounded, saturated result
      if (en2) begin
        vec_p2 <= scaled;
        vld_p2 <= vld_p1;
      end
    end
  end

endmodule

// File: tb/tb_vec_scale.sv
// Bench for vec_scale: table vectors, backpressure, streaming and reset
// sequences, with a scoreboard fed from an independent reference model.
module tb_vec_scale;

  localparam int N = 4;
  localparam int W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            vld_in;
  logic            rdy_out;
  logic [N*W-1:0]  vec_in;
  logic [W-1:0]    scale_in;
  logic            vld_out;
  logic            rdy_in;
  logic [N*W-1:0]  vec_out;

  int passed = 0;
  int total  = 0;
  logic [N*W-1:0] sb[$];

  vec_scale #(.VEC_LEN(N), .DATA_WIDTH(W), .FRAC_BITS(8)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
    .vec_in(vec_in), .scale_in(scale_in), .vld_out(vld_out),
    .rdy_in(rdy_in), .vec_out(vec_out)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic logic [N*W-1:0] pack4(int a, int b, int c, int d);
    logic [N*W-1:0] v;
    v[0*W +: W] = W'(a);
    v[1*W +: W] = W'(b);
    v[2*W +: W] = W'(c);
    v[3*W +: W] = W'(d);
    return v;
  endfunction

  // Reference: exact product, +half, floor-divide by 256, clamp.
  function automatic logic [N*W-1:0] model(logic [N*W-1:0] v, logic [W-1:0] s);
    logic [N*W-1:0] res;
    longint a, b, n, r;
    for (int i = 0; i < N; i++) begin
      a = longint'($signed(v[i*W +: W]));
      b = longint'($signed(s));
      n = a * b + 128;
      if (n >= 0) r = n / 256;
      else        r = -((-n + 255) / 256);
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      res[i*W +: W] = r[W-1:0];
    end
    return res;
  endfunction

  // Scoreboard monitor, sampled mid-cycle where inputs and outputs are stable.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      sb.delete();
    end else if (rst === 1'b0) begin
      if (vld_in && rdy_out) sb.push_back(model(vec_in, scale_in));
      if (vld_out && rdy_in) begin
        if (sb.size() == 0) chk("sb_unexpected_output", 64'(vld_out), 64'd0);
        else chk("sb_data", vec_out, sb.pop_front());
      end
    end
  end

  typedef struct {
    int vin [N];
    int scale;
    int exp [N];
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N*W-1:0] va, vb, vc;
    int sent, cyc;

    tbl[0] = '{vin: '{256, -256, 100, 0},         scale: 512,    exp: '{512, -512, 200, 0}};
    tbl[1] = '{vin: '{3, -3, 1, -1},              scale: 128,    exp: '{2, -1, 1, 0}};
    tbl[2] = '{vin: '{32767, -32768, 20000, -20000}, scale: 512, exp: '{32767, -32768, 32767, -32768}};
    tbl[3] = '{vin: '{100, -100, 7, -7},          scale: -256,   exp: '{-100, 100, -7, 7}};
    tbl[4] = '{vin: '{1, -1, -2, 5},              scale: -128,   exp: '{0, 1, 1, -2}};
    tbl[5] = '{vin: '{-32768, -32768, 32767, -32768}, scale: -32768, exp: '{32767, 32767, -32768, 32767}};

    rst = 1'b1; vld_in = 1'b0; rdy_in = 1'b0; vec_in = '0; scale_in = '0;
    tick();
    chk("reset_rdy_out", 64'(rdy_out), 64'd1);
    chk("reset_vld_out", 64'(vld_out), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_reset_rdy_out", 64'(rdy_out), 64'd1);

    // Table vectors, one at a time, no backpressure.
    rdy_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      vld_in   = 1'b1;
      vec_in   = pack4(tbl[k].vin[0], tbl[k].vin[1], tbl[k].vin[2], tbl[k].vin[3]);
      scale_in = W'(tbl[k].scale);
      tick();
      vld_in = 1'b0;
      chk($sformatf("tbl%0d_lat1_vld", k), 64'(vld_out), 64'd0);
      tick();
      chk($sformatf("tbl%0d_vld", k), 64'(vld_out), 64'd1);
      chk($sformatf("tbl%0d_data", k), vec_out,
          pack4(tbl[k].exp[0], tbl[k].exp[1], tbl[k].exp[2], tbl[k].exp[3]));
      tick();
    end

    // Back-to-back with rdy_in held high: output every cycle.
    for (int k = 0; k < 4; k++) begin
      vld_in = 1'b1;
      vec_in = pack4(k * 10, -k, k + 300, 7);
      scale_in = W'(256 + k);
      tick();
      if (k >= 1) chk($sformatf("b2b_vld%0d", k), 64'(vld_out), 64'd1);
    end
    vld_in = 1'b0;
    tick();
    chk("b2b_vld_last", 64'(vld_out), 64'd1);
    tick();
    tick();

    // Backpressure: A and B fill both stages, C must stall.
    va = pack4(1000, -1000, 5, 6);
    vb = pack4(-7, 8, 9, -10);
    vc = pack4(300, 301, -302, 303);
    rdy_in = 1'b0; vld_in = 1'b1; scale_in = W'(384);
    vec_in = va; #1;
    chk("bp_a_rdy", 64'(rdy_out), 64'd1);
    tick();
    vec_in = vb; #1;
    chk("bp_b_rdy", 64'(rdy_out), 64'd1);
    tick();
    vec_in = vc; #1;
    chk("bp_c_rdy", 64'(rdy_out), 64'd0);
    tick(); tick(); tick();
    chk("bp_hold_rdy", 64'(rdy_out), 64'd0);
    chk("bp_hold_vld", 64'(vld_out), 64'd1);
    chk("bp_hold_data", vec_out, model(va, W'(384)));
    rdy_in = 1'b1; #1;
    chk("bp_release_rdy", 64'(rdy_out), 64'd1);
    tick();
    vld_in = 1'b0;
    chk("bp_out_b", vec_out, model(vb, W'(384)));
    tick();
    chk("bp_out_c", vec_out, model(vc, W'(384)));
    tick();
    chk("bp_drained", 64'(vld_out), 64'd0);

    // Streaming with random downstream stalls.
    sent = 0; cyc = 0;
    vec_in = pack4($urandom_range(0, 65535), $urandom_range(0, 65535),
                   $urandom_range(0, 65535), $urandom_range(0, 65535));
    scale_in = W'($urandom_range(0, 65535));
    while (sent < 10 && cyc < 500) begin
      rdy_in = 1'($urandom_range(0, 1));
      vld_in = 1'b1;
      #1;
      if (rdy_out) begin
        sent++;
        tick();
        vec_in = pack4($urandom_range(0, 65535), $urandom_range(0, 65535),
                       $urandom_range(0, 65535), $urandom_range(0, 65535));
        scale_in = W'($urandom_range(0, 65535));
      end else begin
        tick();
      end
      cyc++;
    end
    chk("stream_all_sent", 64'(sent), 64'd10);
    vld_in = 1'b0; rdy_in = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("stream_drain_empty", 64'(sb.size()), 64'd0);

    // Reset with both stages full.
    rdy_in = 1'b0; vld_in = 1'b1;
    vec_in = pack4(11, 22, 33, 44); scale_in = W'(256);
    tick();
    vec_in = pack4(55, 66, 77, 88);
    tick();
    vld_in = 1'b0;
    chk("rst_full_vld", 64'(vld_out), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_flush_vld", 64'(vld_out), 64'd0);
    chk("rst_flush_rdy", 64'(rdy_out), 64'd1);
    rdy_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rst_no_stale%0d", k), 64'(vld_out), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
